// File: rtl/rv_pkg.sv
// Shared types and constants for the RV32I front end.
//   fetch_state_e : fetch FSM encoding
//   NOP_INSTR     : bubble encoding (addi x0,x0,0)
//   if_id_t       : IF/ID pipeline register contents
//   pc_next       : sequential PC step (32-bit modulo)
package rv_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    DROP  = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        vld;
  } if_id_t;

  function automatic logic [31:0] pc_next(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bundle.
//   req/addr   : fetch request and word address (master -> memory)
//   gnt        : request accepted this cycle (memory -> master)
//   rvalid     : read data valid (memory -> master)
//   rdata      : instruction word (memory -> master)
interface fetch_stage_if;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, addr, input gnt, rvalid, rdata);
  modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/fetch_skid.sv
// One-entry holding buffer for a fetch response that arrives while IF/ID
// is stalled.
//   clk_i, rst_ni     : clock, synchronous active-low reset
//   load_i            : capture {pc_i, instr_i}
//   drain_i           : entry consumed, mark empty
//   clear_i           : flush (wins over load and drain)
//   full_o            : entry holds data
//   pc_o, instr_o     : stored entry
module fetch_skid (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_i,
  input  logic        drain_i,
  input  logic        clear_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] instr_i,
  output logic        full_o,
  output logic [31:0] pc_o,
  output logic [31:0] instr_o
);

  logic        full_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      full_q  <= 1'b0;
      pc_q    <= 32'd0;
      instr_q <= 32'd0;
    end else if (clear_i) begin
      full_q <= 1'b0;
    end else if (load_i) begin
      full_q  <= 1'b1;
      pc_q    <= pc_i;
      instr_q <= instr_i;
    end else if (drain_i) begin
      full_q <= 1'b0;
    end
  end

  assign full_o  = full_q;
  assign pc_o    = pc_q;
  assign instr_o = instr_q;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, issues one instruction fetch at a time and loads
// the IF/ID register. Handles EX redirects, hazard stalls and the flush.
//   i_clk, i_rst_n     : clock, synchronous active-low reset
//   i_stall            : hold IF/ID and PC
//   i_pc_sel           : redirect taken, i_pc_target is the new PC
//   imem               : instruction memory request/response (master)
//   o_if_pc/instr/vld  : IF/ID register
//
// state | meaning
// FETCH | request pc_q (unless stalled with a full skid)
// WAIT  | one request outstanding, its response goes to IF/ID or skid
// DROP  | outstanding response belongs to a flushed path, discard it
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = rv_pkg::NOP_INSTR
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_stall,
  input  logic               i_pc_sel,
  input  logic [31:0]        i_pc_target,
  fetch_stage_if.master      imem,
  output logic [31:0]        o_if_pc,
  output logic [31:0]        o_if_instr,
  output logic               o_if_vld
);
  import rv_pkg::*;

  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  req_pc_q, req_pc_d;
  if_id_t       if_id_q, if_id_d;
  if_id_t       bubble;

  logic         skid_full, skid_load, skid_drain, skid_clear;
  logic [31:0]  skid_pc, skid_instr;
  logic         req, gnt_acc, rsp;

  assign bubble = '{pc: 32'd0, instr: NOP_INSTR, vld: 1'b0};

  // A stalled cycle with a full skid has nowhere to put another response.
  // On the drain cycle (not stalled) the skid empties, so fetching resumes.
  assign req     = i_rst_n && (state_q == FETCH) && (!skid_full || !i_stall);
  assign gnt_acc = req && imem.gnt;
  assign rsp     = imem.rvalid && (state_q != FETCH);

  assign imem.req  = req;
  assign imem.addr = pc_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    if_id_d    = if_id_q;
    skid_load  = 1'b0;
    skid_drain = 1'b0;
    skid_clear = 1'b0;

    if (i_pc_sel) begin
      pc_d       = i_pc_target & ALIGN_MASK;
      if_id_d    = bubble;
      skid_clear = 1'b1;
      if (state_q == FETCH)
        state_d = gnt_acc ? DROP : FETCH;
      else
        state_d = rsp ? FETCH : DROP;
    end else begin
      if (!i_stall) begin
        if (skid_full) begin
          if_id_d    = '{pc: skid_pc, instr: skid_instr, vld: 1'b1};
          skid_drain = 1'b1;
        end else if (state_q == WAIT && rsp) begin
          if_id_d = '{pc: req_pc_q, instr: imem.rdata, vld: 1'b1};
        end else begin
          if_id_d = bubble;
        end
      end

      case (state_q)
        FETCH: begin
          if (gnt_acc) begin
            req_pc_d = pc_q;
            state_d  = WAIT;
          end
        end
        WAIT: begin
          if (rsp) begin
            skid_load = i_stall;
            pc_d      = pc_next(req_pc_q);
            state_d   = FETCH;
          end
        end
        DROP: begin
          if (rsp) state_d = FETCH;
        end
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= FETCH;
      pc_q     <= RESET_PC & ALIGN_MASK;
      req_pc_q <= 32'd0;
      if_id_q  <= bubble;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      if_id_q  <= if_id_d;
    end
  end

  fetch_skid u_skid (
    .clk_i   (i_clk),
    .rst_ni  (i_rst_n),
    .load_i  (skid_load),
    .drain_i (skid_drain),
    .clear_i (skid_clear),
    .pc_i    (req_pc_q),
    .instr_i (imem.rdata),
    .full_o  (skid_full),
    .pc_o    (skid_pc),
    .instr_o (skid_instr)
  );

  assign o_if_pc    = if_id_q.pc;
  assign o_if_instr = if_id_q.instr;
  assign o_if_vld   = if_id_q.vld;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed cycle table, hand sequences for PC wrap
// and reset mid-request, then randomized traffic checked against a
// program-order model of what the decoder should consume.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, stall, pc_sel;
  logic [31:0] pc_target;
  logic [31:0] if_pc, if_instr;
  logic        if_vld;
  logic        stall2, sel2;
  logic [31:0] tgt2;
  logic [31:0] if_pc2, if_instr2;
  logic        if_vld2;

  fetch_stage_if imem ();
  fetch_stage_if imem2 ();

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_stall(stall), .i_pc_sel(pc_sel),
    .i_pc_target(pc_target), .imem(imem),
    .o_if_pc(if_pc), .o_if_instr(if_instr), .o_if_vld(if_vld)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .i_clk(clk), .i_rst_n(rst_n), .i_stall(stall2), .i_pc_sel(sel2),
    .i_pc_target(tgt2), .imem(imem2),
    .o_if_pc(if_pc2), .o_if_instr(if_instr2), .o_if_vld(if_vld2)
  );

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] memw(input logic [31:0] a);
    if (a == 32'd0) return 32'h0050_0093;
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  typedef struct {
    logic        stall, sel;
    logic [31:0] tgt;
    logic        gnt, rv;
    logic [31:0] rdata;
    logic        ereq;
    logic [31:0] eaddr;
    logic        evld;
    logic [31:0] epc, einstr;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic s, input logic sl, input logic [31:0] t,
                     input logic g, input logic r, input logic [31:0] d,
                     input logic eq, input logic [31:0] ea,
                     input logic ev, input logic [31:0] ep, input logic [31:0] ei);
    vec_t v;
    v.stall = s; v.sel = sl; v.tgt = t; v.gnt = g; v.rv = r; v.rdata = d;
    v.ereq = eq; v.eaddr = ea; v.evld = ev; v.epc = ep; v.einstr = ei;
    tbl.push_back(v);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // random-phase model state
  bit          pending;
  int          cnt;
  logic [31:0] paddr, exp_pc;
  int          consumed;
  logic        pre_vld, pre_req;
  logic [31:0] pre_pc, pre_instr, pre_addr;

  initial begin
    rst_n = 1'b0; stall = 1'b0; pc_sel = 1'b0; pc_target = 32'd0;
    imem.gnt = 1'b0; imem.rvalid = 1'b0; imem.rdata = 32'd0;
    stall2 = 1'b0; sel2 = 1'b0; tgt2 = 32'd0;
    imem2.gnt = 1'b0; imem2.rvalid = 1'b0; imem2.rdata = 32'd0;

    // ---------------- reset state ----------------
    @(negedge clk); @(negedge clk);
    imem.gnt = 1'b1; imem2.gnt = 1'b1;
    #1;
    chk("rst.req", imem.req, 1'b0);
    chk("rst.req_wrap", imem2.req, 1'b0);
    chk("rst.vld", if_vld, 1'b0);
    chk("rst.instr", if_instr, NOP);
    chk("rst.pc", if_pc, 32'd0);
    @(negedge clk);
    imem.gnt = 1'b0; imem2.gnt = 1'b0;
    rst_n = 1'b1;

    // ---------------- directed table ----------------
    //   stall sel tgt      gnt rv rdata          req addr       vld pc         instr
    add(0, 0, 32'h0,   1, 0, 32'h0,          1, 32'h0,   0, 32'h0,   NOP);
    add(0, 0, 32'h0,   1, 1, memw(32'h0),    0, 32'h0,   0, 32'h0,   NOP);
    add(0, 0, 32'h0,   1, 0, 32'h0,          1, 32'h4,   1, 32'h0,   memw(32'h0));
    add(0, 0, 32'h0,   1, 1, memw(32'h4),    0, 32'h0,   0, 32'h0,   NOP);
    add(0, 0, 32'h0,   1, 0, 32'h0,          1, 32'h8,   1, 32'h4,   memw(32'h4));
    add(0, 1, 32'h102, 0, 0, 32'h0,          0, 32'h0,   0, 32'h0,   NOP);
    add(0, 0, 32'h0,   1, 1, memw(32'h8),    0, 32'h0,   0, 32'h0,   NOP);
    add(0, 0, 32'h0,   1, 0, 32'h0,          1, 32'h100, 0, 32'h0,   NOP);
    add(0, 0, 32'h0,   1, 1, memw(32'h100),  0, 32'h0,   0, 32'h0,   NOP);
    add(1, 0, 32'h0,   1, 0, 32'h0,          1, 32'h104, 1, 32'h100, memw(32'h100));
    add(1, 0, 32'h0,   1, 1, memw(32'h104),  0, 32'h0,   1, 32'h100, memw(32'h100));
    add(1, 0, 32'h0,   1, 0, 32'h0,          0, 32'h0,   1, 32'h100, memw(32'h100));
    add(0, 0, 32'h0,   1, 0, 32'h0,          1, 32'h108, 1, 32'h100, memw(32'h100));
    add(0, 0, 32'h0,   1, 1, memw(32'h108),  0, 32'h0,   1, 32'h104, memw(32'h104));
    add(0, 0, 32'h0,   0, 0, 32'h0,          1, 32'h10C, 1, 32'h108, memw(32'h108));
    add(0, 0, 32'h0,   1, 0, 32'h0,          1, 32'h10C, 0, 32'h0,   NOP);
    add(1, 1, 32'h20,  0, 1, memw(32'h10C),  0, 32'h0,   0, 32'h0,   NOP);
    add(0, 0, 32'h0,   1, 0, 32'h0,          1, 32'h20,  0, 32'h0,   NOP);
    add(0, 0, 32'h0,   0, 1, memw(32'h20),   0, 32'h0,   0, 32'h0,   NOP);
    add(1, 1, 32'h40,  1, 0, 32'h0,          1, 32'h24,  1, 32'h20,  memw(32'h20));
    add(0, 0, 32'h0,   1, 1, memw(32'h24),   0, 32'h0,   0, 32'h0,   NOP);
    add(0, 0, 32'h0,   1, 0, 32'h0,          1, 32'h40,  0, 32'h0,   NOP);
    add(0, 0, 32'h0,   0, 1, memw(32'h40),   0, 32'h0,   0, 32'h0,   NOP);
    add(0, 0, 32'h0,   0, 0, 32'h0,          1, 32'h44,  1, 32'h40,  memw(32'h40));

    for (int i = 0; i < tbl.size(); i++) begin
      if (i != 0) @(negedge clk);
      stall = tbl[i].stall; pc_sel = tbl[i].sel; pc_target = tbl[i].tgt;
      imem.gnt = tbl[i].gnt; imem.rvalid = tbl[i].rv; imem.rdata = tbl[i].rdata;
      #1;
      chk($sformatf("vec%0d.req", i), imem.req, tbl[i].ereq);
      if (tbl[i].ereq) chk($sformatf("vec%0d.addr", i), imem.addr, tbl[i].eaddr);
      chk($sformatf("vec%0d.vld", i), if_vld, tbl[i].evld);
      if (tbl[i].evld) chk($sformatf("vec%0d.pc", i), if_pc, tbl[i].epc);
      chk($sformatf("vec%0d.instr", i), if_instr, tbl[i].einstr);
    end
    @(negedge clk);
    stall = 1'b0; pc_sel = 1'b0; pc_target = 32'd0;
    imem.gnt = 1'b0; imem.rvalid = 1'b0; imem.rdata = 32'd0;

    // ---------------- PC wrap from 0xFFFF_FFFC ----------------
    imem2.gnt = 1'b1;
    #1;
    chk("wrap.req0", imem2.req, 1'b1);
    chk("wrap.addr0", imem2.addr, 32'hFFFF_FFFC);
    @(negedge clk);
    imem2.gnt = 1'b0; imem2.rvalid = 1'b1; imem2.rdata = 32'h0000_0011;
    #1;
    chk("wrap.wait_req", imem2.req, 1'b0);
    @(negedge clk);
    imem2.gnt = 1'b1; imem2.rvalid = 1'b0;
    #1;
    chk("wrap.req1", imem2.req, 1'b1);
    chk("wrap.addr1", imem2.addr, 32'h0);
    chk("wrap.if_vld", if_vld2, 1'b1);
    chk("wrap.if_pc", if_pc2, 32'hFFFF_FFFC);
    chk("wrap.if_instr", if_instr2, 32'h0000_0011);
    @(negedge clk);
    imem2.gnt = 1'b0;

    // ---------------- reset while a request is outstanding ----------------
    imem.gnt = 1'b1;
    #1;
    chk("rstmid.req", imem.req, 1'b1);
    chk("rstmid.addr", imem.addr, 32'h44);
    @(negedge clk);
    imem.gnt = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    imem.gnt = 1'b1;
    #1;
    chk("rstmid.req_low", imem.req, 1'b0);
    chk("rstmid.vld", if_vld, 1'b0);
    chk("rstmid.pc", if_pc, 32'h0);
    @(negedge clk);
    rst_n = 1'b1; imem.gnt = 1'b0; imem.rvalid = 1'b1; imem.rdata = 32'hDEAD_BEEF;
    #1;
    chk("rstmid.req_after", imem.req, 1'b1);
    chk("rstmid.addr_after", imem.addr, 32'h0);
    @(negedge clk);
    imem.rvalid = 1'b0; imem.gnt = 1'b1;
    #1;
    chk("rstmid.late_ignored", if_vld, 1'b0);
    chk("rstmid.late_instr", if_instr, NOP);
    chk("rstmid.addr_kept", imem.addr, 32'h0);
    @(negedge clk);
    imem.gnt = 1'b0; imem.rvalid = 1'b1; imem.rdata = memw(32'h0);
    @(negedge clk);
    imem.rvalid = 1'b0;
    #1;
    chk("rstmid.first_vld", if_vld, 1'b1);
    chk("rstmid.first_pc", if_pc, 32'h0);
    chk("rstmid.first_instr", if_instr, memw(32'h0));

    // ---------------- randomized traffic ----------------
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    pending = 1'b0; cnt = 0; paddr = 32'd0; exp_pc = 32'd0; consumed = 0;

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      stall     = ($urandom_range(0, 3) == 0);
      pc_sel    = ($urandom_range(0, 24) == 0);
      pc_target = 32'($urandom_range(0, 1023));
      imem.gnt  = ($urandom_range(0, 2) != 0);
      if (pending && cnt == 0) begin
        imem.rvalid = 1'b1; imem.rdata = memw(paddr);
      end else begin
        imem.rvalid = 1'b0; imem.rdata = $urandom;
      end
      #1;
      pre_vld = if_vld; pre_pc = if_pc; pre_instr = if_instr;
      pre_req = imem.req; pre_addr = imem.addr;

      if (pre_vld) begin
        chk("rnd.pc", pre_pc, exp_pc);
        chk("rnd.instr", pre_instr, memw(exp_pc));
        if (!stall && !pc_sel) begin
          exp_pc = exp_pc + 32'd4;
          consumed++;
        end
      end else begin
        chk("rnd.bubble", pre_instr, NOP);
      end
      if (pending) chk("rnd.one_outstanding", pre_req, 1'b0);
      if (pre_req) chk("rnd.align", pre_addr & 32'h3, 32'h0);

      @(posedge clk);
      #1;
      if (pc_sel) begin
        exp_pc = pc_target & 32'hFFFF_FFFC;
        chk("rnd.flush_vld", if_vld, 1'b0);
        chk("rnd.flush_instr", if_instr, NOP);
      end else if (stall) begin
        chk("rnd.hold_vld", if_vld, pre_vld);
        chk("rnd.hold_pc", if_pc, pre_pc);
        chk("rnd.hold_instr", if_instr, pre_instr);
      end

      if (imem.rvalid) pending = 1'b0;
      else if (pending && cnt != 0) cnt--;
      if (pre_req && imem.gnt) begin
        pending = 1'b1;
        paddr   = pre_addr;
        cnt     = $urandom_range(0, 2);
      end
    end
    chk("rnd.progress", (consumed > 100) ? 32'd1 : 32'd0, 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
IF stage of the 5-stage RV32I pipeline. It owns the PC, issues instruction-memory requests, and loads the IF/ID pipeline register with {pc, instr, valid}; the instruction output drives the decode-stage control unit's i_instr. It handles branch/jump redirects coming back from EX, pipeline stalls from the hazard unit, and the flush that follows a taken redirect.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0) placed in IF/ID on flush and reset.

Ports:
i_clk  in  1  clock, rising edge.
i_rst_n  in  1  reset, synchronous, active-low.
i_stall  in  1  hazard unit: hold IF/ID and PC.
i_pc_sel  in  1  EX: redirect taken (branch taken / JAL / JALR).
i_pc_target  in  32  EX: redirect target (ALU result).
o_imem_req  out  1  instruction fetch request.
o_imem_addr  out  32  fetch address, word-aligned.
i_imem_gnt  in  1  request accepted this cycle.
i_imem_rvalid  in  1  read data valid; latency >= 1 cycle after gnt.
i_imem_rdata  in  32  instruction word.
o_if_pc  out  32  IF/ID: PC of the held instruction.
o_if_instr  out  32  IF/ID: instruction to decode.
o_if_vld  out  1  IF/ID: entry holds a real instruction.

Behaviour:
- Reset (i_rst_n=0 at a clock edge): pc_q=RESET_PC, state=FETCH, skid empty, o_if_vld=0, o_if_instr=NOP_INSTR, o_if_pc=0. o_imem_req=0 while i_rst_n=0.
- One outstanding request at most. Best-case throughput is 1 instruction per 2 cycles with 1-cycle imem. Latency is gnt edge -> rvalid -> IF/ID valid on the edge where rvalid is sampled.
- FSM states:
  - FETCH: o_imem_req=1 unless the skid is full; o_imem_addr=pc_q. When gnt is sampled: req_pc<=pc_q, go to WAIT.
  - WAIT: o_imem_req=0. When rvalid is sampled:
    - if IF/ID can accept (i_stall=0): IF/ID<={req_pc, rdata, 1}.
    - otherwise the skid buffer captures {req_pc, rdata}.
    - In both cases pc_q<=req_pc+4, go to FETCH.
  - DROP: o_imem_req=0. The next rvalid is discarded, then go to FETCH. pc_q already holds the redirect target.
- Redirect (i_pc_sel=1) has highest priority, including over i_stall:
  - pc_q<=i_pc_target & 32'hFFFF_FFFC.
  - IF/ID<={0, NOP_INSTR, 0}; skid cleared.
  - If a request is outstanding (WAIT), or gnt is sampled in the same cycle: go to DROP.
  - If rvalid is sampled in the same cycle: the data is discarded, go to FETCH.
  - Otherwise go to FETCH.
- Stall (i_stall=1, no redirect): o_if_* and pc_q hold. Only a returning response may proceed, and it goes into the skid. No new request is issued while the skid is full.
- Skid drain: the first non-stalled cycle loads IF/ID from the skid and empties it. New fetch requests resume the same cycle.
- IF/ID advance with nothing new: when not stalled and no data arrives, o_if_vld<=0 and o_if_instr<=NOP_INSTR. The decoder never sees a stale instruction twice.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC+4 wraps to 0, no flag.
- Reset mid-request: state returns to FETCH. A late rvalid arriving in FETCH state is ignored.

Decomposition:
- rv_pkg: fetch_state_e {FETCH, WAIT, DROP}; NOP_INSTR constant; if_id_t struct {pc, instr, vld}.
- Sub-module fetch_skid: 1-entry buffer with load/drain/clear and full flag.

Test Plan:
- Reset with RESET_PC=0; imem gnt always 1, rvalid 1 cycle later, mem[0]=32'h00500093 -> first request addr 0. IF/ID={0, 32'h00500093, 1} two cycles after reset release. Next addr is 4.
- Sequential fetch over 4 words -> o_if_pc sequence 0, 4, 8, C, each valid with a NOP bubble between; no address skipped.
- Redirect i_pc_sel=1, i_pc_target=32'h0000_0102 while WAIT for addr 8 -> data for 8 dropped, next request addr 32'h100, IF/ID vld=0 during the drop.
- i_stall=1 for 3 cycles while a response for addr C returns -> IF/ID holds previous entry. After stall release IF/ID={C, data, 1}, then fetch of 0x10 resumes.
- Redirect and stall asserted together -> redirect wins: IF/ID flushed to NOP, pc_q=target.
- RESET_PC=32'hFFFF_FFFC -> second request addr 0.
